// File: rtl/spi_pkg.sv
// Shared constants and channel payload type for the SPI memory slave front end.
package spi_pkg;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 3;
  localparam int unsigned DEF_CNT_W           = 8;

  // Conditioned level plus its registered edge pulses for one pad channel.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_t;

endpackage

// File: rtl/input_conditioner_bit.sv
// One pad channel: flop-chain synchronizer followed by a counting debouncer
// that registers the accepted level and a one-cycle rise/fall pulse.
module input_conditioner_bit #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned CNT_W           = 8,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic s_clk,
  input  logic rst_n,
  input  logic raw,
  output logic cond,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       n;

  // Metastability chain; reset to the idle level so release is silent.
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      cond <= RESET_VAL;
      n    <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == cond) begin
        n <= '0;
      end else if (n == CNT_LAST) begin
        cond <= s;
        n    <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        n <= n + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_input_conditioner.sv
// SPI pad front end: conditions sclk/mosi/cs and produces frame and
// frame-qualified sclk edge pulses for the control FSM and shift register.
module spi_input_conditioner
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic s_clk,
  input  logic rst_n,
  input  logic sclk_raw,
  input  logic mosi_raw,
  input  logic cs_raw,
  output logic sclk_cond,
  output logic mosi_cond,
  output logic cs_cond,
  output logic sclk_pos_edge,
  output logic sclk_neg_edge,
  output logic frame_start,
  output logic frame_end
);

  chan_t sclk_ch;
  chan_t mosi_ch;
  chan_t cs_ch;
  logic  unused_mosi_edges;

  input_conditioner_bit #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (SCLK_IDLE)
  ) u_sclk (
    .s_clk(s_clk),
    .rst_n(rst_n),
    .raw  (sclk_raw),
    .cond (sclk_ch.level),
    .rise (sclk_ch.rise),
    .fall (sclk_ch.fall)
  );

  input_conditioner_bit #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (MOSI_IDLE)
  ) u_mosi (
    .s_clk(s_clk),
    .rst_n(rst_n),
    .raw  (mosi_raw),
    .cond (mosi_ch.level),
    .rise (mosi_ch.rise),
    .fall (mosi_ch.fall)
  );

  input_conditioner_bit #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (CS_IDLE)
  ) u_cs (
    .s_clk(s_clk),
    .rst_n(rst_n),
    .raw  (cs_raw),
    .cond (cs_ch.level),
    .rise (cs_ch.rise),
    .fall (cs_ch.fall)
  );

  // MOSI is sampled by level only; its edge pulses have no consumer.
  assign unused_mosi_edges = mosi_ch.rise ^ mosi_ch.fall;

  assign sclk_cond   = sclk_ch.level;
  assign mosi_cond   = mosi_ch.level;
  assign cs_cond     = cs_ch.level;
  assign frame_start = cs_ch.fall;
  assign frame_end   = cs_ch.rise;

  // Both terms are registered in the same cycle, so a simultaneous cs fall
  // passes the sclk edge and a simultaneous cs rise blocks it.
  assign sclk_pos_edge = sclk_ch.rise & (cs_ch.level != CS_IDLE);
  assign sclk_neg_edge = sclk_ch.fall & (cs_ch.level != CS_IDLE);

endmodule

// File: doc/spi_input_conditioner.md
Name: spi_input_conditioner

Overview:
- Front end of the SPI memory slave. It sits directly upstream of the SPI control FSM and the shift register.
- Takes the raw asynchronous pad signals sclk, mosi and cs, and synchronizes, debounces and edge-detects each one.
- Outputs are clean levels plus single-cycle edge pulses, all in the s_clk domain, that the FSM and shift register consume.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each synchronizer chain; legal values 2..4.
- DEBOUNCE_CYCLES, 3, consecutive cycles a synchronized value must differ from the conditioned value before it is accepted; legal values 1..255.
- CNT_W, 8, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- s_clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sclk_raw  input  1  SPI clock from the pad; asynchronous.
- mosi_raw  input  1  SPI data in from the pad; asynchronous.
- cs_raw  input  1  SPI chip select from the pad; active-low; asynchronous.
- sclk_cond  output  1  conditioned SPI clock level.
- mosi_cond  output  1  conditioned MOSI level.
- cs_cond  output  1  conditioned chip select level; 1 = deselected.
- sclk_pos_edge  output  1  one-cycle pulse on a rising edge of sclk_cond, qualified by an active frame.
- sclk_neg_edge  output  1  one-cycle pulse on a falling edge of sclk_cond, qualified by an active frame.
- frame_start  output  1  one-cycle pulse when cs_cond falls.
- frame_end  output  1  one-cycle pulse when cs_cond rises.

Behaviour:
- Reset is asynchronous and active-low (rst_n = 0). Reset values:
  - sclk and mosi synchronizer flops, conditioned levels and counters: 0.
  - cs synchronizer flops and cs_cond: 1 (deselected).
  - All pulse outputs: 0.
- Reset asserted mid-frame forces the reset values immediately. No edge or frame pulse is generated by reset assertion or release.
- Each channel is an identical pipeline: a SYNC_STAGES flop chain producing s, followed by a debouncer holding the conditioned value c and a counter n. Every cycle:
  - s == c: n <= 0.
  - s != c and n == DEBOUNCE_CYCLES-1: c <= ~c, n <= 0, and the channel's rise or fall pulse is registered high for exactly one cycle.
  - Otherwise: n <= n+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output is fully rejected; the counter restarts at 0.
- Latency: a clean raw transition shows on c and on its pulse at the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising s_clk edge after the change. The default is 5 cycles.
- Every pulse asserts in the same cycle as the new c value and deasserts on the next cycle. The minimum pulse spacing per channel is DEBOUNCE_CYCLES cycles.
- Qualification of the sclk pulses:
  - sclk_pos_edge = sclk rise pulse AND (cs_cond == 0), using the cs_cond value present in that same output cycle.
  - sclk_neg_edge is qualified the same way.
  - Consequently, if cs_cond falls and sclk_cond rises in the same cycle, the sclk edge is passed. If cs_cond rises in the same cycle as an sclk edge, that edge is suppressed.
- frame_start and frame_end are the cs fall and rise pulses and are not qualified.
- The conditioned levels are always driven, independent of cs.
- No other state; there is no FSM beyond the per-channel debouncers. Counters never wrap, because they reset to 0 at DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package spi_pkg holds:
  - CS_IDLE = 1 and SCLK_IDLE = 0.
  - Default SYNC_STAGES and DEBOUNCE_CYCLES.
- One sub-module, input_conditioner_bit, implements a single channel:
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W, RESET_VAL.
  - Ports: s_clk, rst_n, raw, cond, rise, fall.
- The top level instantiates input_conditioner_bit three times and adds the cs qualification gating.

Test Plan:
- Reset: hold rst_n = 0 with raw inputs toggling -> sclk_cond = 0, mosi_cond = 0, cs_cond = 1, all pulses 0. Release -> no pulse in the first 10 cycles while raws sit at their idle levels.
- Latency: cs_raw 1->0 at cycle 0 (defaults) -> cs_cond = 0 and frame_start = 1 at exactly cycle 5 only. Then sclk_raw 0->1 -> sclk_cond = 1 and sclk_pos_edge = 1 for exactly one cycle, 5 cycles later.
- Glitch rejection: mosi_raw high for 2 cycles, then low -> mosi_cond stays 0 and the counter returns to 0. A high lasting 3+ cycles -> mosi_cond = 1.
- Qualification: with cs_raw = 1, toggle sclk_raw 8 times with a 10-cycle half-period -> sclk_cond toggles 8 times and sclk_pos_edge / sclk_neg_edge stay 0. Repeat with cs_raw = 0 -> 4 pos and 4 neg pulses.
- Same-cycle events: align cs_raw fall with sclk_raw rise -> frame_start and sclk_pos_edge both 1 in the same cycle. Align cs_raw rise with sclk_raw fall -> frame_end = 1 and sclk_neg_edge = 0.
- Reset mid-frame: drop rst_n while cs_cond = 0 and a counter is mid-count -> cs_cond = 1 and counters = 0 immediately, with no frame_end pulse.
